// File: rtl/periph_port_arbiter.sv
// Round-robin arbiter sharing one peripheral slave port among NB_CORES cores.
// Responses return in order through an ID FIFO; a watchdog forces an error reply on a stalled slave.
module periph_port_arbiter #(
    parameter int NB_CORES        = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int BE_WIDTH        = DATA_WIDTH / 8,
    parameter int MAX_OUTSTANDING = 2,
    parameter int TIMEOUT         = 255
) (
    input  logic                                 clk,
    input  logic                                 rst_i,
    input  logic [NB_CORES-1:0]                  data_req_i,
    input  logic [NB_CORES-1:0][ADDR_WIDTH-1:0]  data_add_i,
    input  logic [NB_CORES-1:0]                  data_wen_i,
    input  logic [NB_CORES-1:0][DATA_WIDTH-1:0]  data_wdata_i,
    input  logic [NB_CORES-1:0][BE_WIDTH-1:0]    data_be_i,
    output logic [NB_CORES-1:0]                  data_gnt_o,
    output logic [NB_CORES-1:0]                  data_r_valid_o,
    output logic [DATA_WIDTH-1:0]                data_r_rdata_o,
    output logic                                 data_r_opc_o,
    output logic                                 per_req_o,
    output logic [ADDR_WIDTH-1:0]                per_add_o,
    output logic                                 per_wen_o,
    output logic [DATA_WIDTH-1:0]                per_wdata_o,
    output logic [BE_WIDTH-1:0]                  per_be_o,
    input  logic                                 per_gnt_i,
    input  logic                                 per_r_valid_i,
    input  logic [DATA_WIDTH-1:0]                per_r_rdata_i,
    input  logic                                 per_r_opc_i,
    output logic                                 spurious_rsp_o
);

    localparam int IDW = (NB_CORES > 1) ? $clog2(NB_CORES) : 1;
    localparam int PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int TW  = $clog2(TIMEOUT + 1);

    logic [IDW-1:0] r_rr_ptr;
    logic           r_lock;
    logic [IDW-1:0] r_lock_id;
    logic [IDW-1:0] r_fifo_mem [MAX_OUTSTANDING];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic [TW-1:0]  r_wdog;
    logic           r_spurious;

    logic [IDW-1:0] w_sel;
    logic           w_found;
    int             w_scan;
    logic [IDW-1:0] w_scan_idx;
    logic [IDW-1:0] w_head;
    logic [IDW-1:0] w_rr_next;
    logic           w_fifo_empty;
    logic           w_fifo_full;
    logic           w_fifo_block;
    logic           w_timeout;
    logic           w_pop;
    logic           w_handshake;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
    endfunction

    // A locked request keeps the slave port until it is granted, regardless of new requesters.
    always_comb begin
        w_sel      = r_rr_ptr;
        w_found    = 1'b0;
        w_scan     = 0;
        w_scan_idx = '0;
        if (r_lock) begin
            w_sel = r_lock_id;
        end else begin
            for (int k = 0; k < NB_CORES; k++) begin
                w_scan = int'(r_rr_ptr) + k;
                if (w_scan >= NB_CORES) w_scan = w_scan - NB_CORES;
                w_scan_idx = w_scan[IDW-1:0];
                if (!w_found && data_req_i[w_scan_idx]) begin
                    w_found = 1'b1;
                    w_sel   = w_scan_idx;
                end
            end
        end
    end

    assign w_fifo_empty = (r_count == '0);
    assign w_fifo_full  = (r_count == CW'(MAX_OUTSTANDING));
    assign w_head       = r_fifo_mem[r_rd_ptr];
    assign w_timeout    = ~w_fifo_empty & ~per_r_valid_i & (r_wdog == TW'(TIMEOUT - 1));
    assign w_pop        = ~w_fifo_empty & (per_r_valid_i | w_timeout);
    assign w_fifo_block = w_fifo_full & ~w_pop;
    assign w_rr_next    = (w_sel == IDW'(NB_CORES - 1)) ? '0 : w_sel + IDW'(1);

    assign per_req_o    = data_req_i[w_sel] & ~w_fifo_block;
    assign per_add_o    = data_add_i[w_sel];
    assign per_wen_o    = data_wen_i[w_sel];
    assign per_wdata_o  = data_wdata_i[w_sel];
    assign per_be_o     = data_be_i[w_sel];
    assign w_handshake  = per_req_o & per_gnt_i;

    // A forced timeout reply carries zero data and an error flag.
    assign data_r_rdata_o = (per_r_valid_i & ~w_fifo_empty) ? per_r_rdata_i : '0;
    assign data_r_opc_o   = w_pop & (per_r_valid_i ? per_r_opc_i : 1'b1);
    assign spurious_rsp_o = r_spurious;

    generate
        for (genvar gi = 0; gi < NB_CORES; gi++) begin : g_port
            assign data_gnt_o[gi]     = w_handshake & (w_sel == IDW'(gi));
            assign data_r_valid_o[gi] = w_pop & (w_head == IDW'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (w_handshake) r_fifo_mem[r_wr_ptr] <= w_sel;
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            r_rr_ptr   <= '0;
            r_lock     <= 1'b0;
            r_lock_id  <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_wdog     <= '0;
            r_spurious <= 1'b0;
        end else begin
            if (w_handshake) begin
                r_rr_ptr <= w_rr_next;
                r_lock   <= 1'b0;
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end else if (per_req_o) begin
                r_lock    <= 1'b1;
                r_lock_id <= w_sel;
            end
            if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_count <= r_count + CW'(w_handshake) - CW'(w_pop);
            // Each new FIFO head starts its wait from zero.
            if (w_fifo_empty || w_pop) r_wdog <= '0;
            else                       r_wdog <= r_wdog + TW'(1);
            if (per_r_valid_i && w_fifo_empty) r_spurious <= 1'b1;
        end
    end

endmodule

// File: tb/tb_periph_port_arbiter.sv
// Bench for periph_port_arbiter: directed vector table, corner-case sequences,
// and random traffic against a queue-based reference model.
module tb_periph_port_arbiter;

    localparam int NB = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int MO = 2;
    localparam int TO = 4;

    logic                 clk = 1'b0;
    logic                 rst_i;
    logic [NB-1:0]        data_req_i;
    logic [NB-1:0][AW-1:0] data_add_i;
    logic [NB-1:0]        data_wen_i;
    logic [NB-1:0][DW-1:0] data_wdata_i;
    logic [NB-1:0][BW-1:0] data_be_i;
    logic [NB-1:0]        data_gnt_o;
    logic [NB-1:0]        data_r_valid_o;
    logic [DW-1:0]        data_r_rdata_o;
    logic                 data_r_opc_o;
    logic                 per_req_o;
    logic [AW-1:0]        per_add_o;
    logic                 per_wen_o;
    logic [DW-1:0]        per_wdata_o;
    logic [BW-1:0]        per_be_o;
    logic                 per_gnt_i;
    logic                 per_r_valid_i;
    logic [DW-1:0]        per_r_rdata_i;
    logic                 per_r_opc_i;
    logic                 spurious_rsp_o;

    always #5 clk = ~clk;

    periph_port_arbiter #(
        .NB_CORES(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW),
        .MAX_OUTSTANDING(MO), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_i(rst_i),
        .data_req_i(data_req_i), .data_add_i(data_add_i), .data_wen_i(data_wen_i),
        .data_wdata_i(data_wdata_i), .data_be_i(data_be_i),
        .data_gnt_o(data_gnt_o), .data_r_valid_o(data_r_valid_o),
        .data_r_rdata_o(data_r_rdata_o), .data_r_opc_o(data_r_opc_o),
        .per_req_o(per_req_o), .per_add_o(per_add_o), .per_wen_o(per_wen_o),
        .per_wdata_o(per_wdata_o), .per_be_o(per_be_o),
        .per_gnt_i(per_gnt_i), .per_r_valid_i(per_r_valid_i),
        .per_r_rdata_i(per_r_rdata_i), .per_r_opc_i(per_r_opc_i),
        .spurious_rsp_o(spurious_rsp_o)
    );

    int total = 0;
    int bad   = 0;

    logic [3:0]  nxt_wen = 4'b0101;
    logic [15:0] nxt_be  = 16'h4321;

    typedef struct {
        logic [3:0]  req;
        logic        gnt;
        logic        rv;
        logic        opc;
        logic [31:0] rd;
        logic        exp_preq;
        int          exp_sel;
        logic [3:0]  exp_gnt;
        logic [3:0]  exp_rv;
        logic        exp_opc;
    } vec_t;

    vec_t tbl[19];

    function automatic vec_t mk(input int req, input int g, input int rv, input int opc,
                                input int rd, input int preq, input int sel,
                                input int eg, input int erv, input int eopc);
        vec_t v;
        v.req = 4'(req); v.gnt = 1'(g); v.rv = 1'(rv); v.opc = 1'(opc); v.rd = 32'(rd);
        v.exp_preq = 1'(preq); v.exp_sel = sel; v.exp_gnt = 4'(eg);
        v.exp_rv = 4'(erv); v.exp_opc = 1'(eopc);
        return v;
    endfunction

    function automatic logic [31:0] core_addr(input int c);
        return 32'h1000_0000 + 32'(c) * 32'h10;
    endfunction

    function automatic logic [31:0] core_wdata(input int c);
        return 32'hA5A5_0000 + 32'(c);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] eg, input logic [3:0] erv,
                           input logic eopc, input logic [31:0] erd, input logic epreq);
        chk({tag, "_gnt"},   64'(data_gnt_o),     64'(eg));
        chk({tag, "_rv"},    64'(data_r_valid_o), 64'(erv));
        chk({tag, "_opc"},   64'(data_r_opc_o),   64'(eopc));
        chk({tag, "_rdata"}, 64'(data_r_rdata_o), 64'(erd));
        chk({tag, "_preq"},  64'(per_req_o),      64'(epreq));
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled at the falling edge.
    task automatic drive(input logic [3:0] req, input logic g, input logic rv,
                         input logic opc, input logic [31:0] rd);
        @(posedge clk); #1;
        data_req_i = req; per_gnt_i = g; per_r_valid_i = rv;
        per_r_opc_i = opc; per_r_rdata_i = rd;
        data_wen_i = nxt_wen; data_be_i = nxt_be;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_i = 1'b1;
        data_req_i = '0; per_gnt_i = 1'b0; per_r_valid_i = 1'b0;
        per_r_opc_i = 1'b0; per_r_rdata_i = '0;
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(negedge clk);
    endtask

    // Reference model: outstanding IDs as a queue, head wait time as a plain counter.
    int         m_rr, m_lock, m_lock_id, m_wait;
    bit         m_spur;
    int         m_q[$];
    int         e_sel;
    bit         e_preq, e_pop, e_opc;
    logic [3:0] e_gnt, e_rv;
    logic [31:0] e_rd;

    task automatic model_reset();
        m_rr = 0; m_lock = 0; m_lock_id = 0; m_wait = 0; m_spur = 0;
        m_q.delete();
    endtask

    task automatic model_eval(input logic [3:0] req, input logic g, input logic rv,
                              input logic opc, input logic [31:0] rd);
        bit full, tmo;
        e_sel = -1;
        if (m_lock != 0) e_sel = m_lock_id;
        else for (int k = 0; k < NB; k++)
            if (e_sel < 0 && req[(m_rr + k) % NB]) e_sel = (m_rr + k) % NB;
        tmo    = (m_q.size() > 0) && !rv && (m_wait + 1 == TO);
        e_pop  = (m_q.size() > 0) && (rv || tmo);
        full   = (m_q.size() == MO);
        e_preq = (e_sel >= 0) && req[e_sel] && !(full && !e_pop);
        e_gnt  = (e_preq && g) ? 4'(1 << e_sel) : 4'h0;
        e_rv   = e_pop ? 4'(1 << m_q[0]) : 4'h0;
        e_opc  = e_pop && (rv ? opc : 1'b1);
        e_rd   = (e_pop && rv) ? rd : 32'h0;
    endtask

    task automatic model_commit(input logic g, input logic rv);
        bit hs, was_empty;
        hs = e_preq && g;
        was_empty = (m_q.size() == 0);
        if (hs) begin
            m_rr = (e_sel + 1) % NB; m_lock = 0;
        end else if (e_preq) begin
            m_lock = 1; m_lock_id = e_sel;
        end
        if (rv && was_empty) m_spur = 1;
        if (e_pop || was_empty) m_wait = 0;
        else m_wait++;
        if (e_pop) void'(m_q.pop_front());
        if (hs) m_q.push_back(e_sel);
    endtask

    initial begin
        vec_t        v;
        logic [3:0]  r_req;
        logic        r_g, r_rv, r_opc;
        logic [31:0] r_rd;
        logic [31:0] pq_d[$];
        int          pq_t[$];
        int          n_hs, n_gnt1, n_rv1;

        rst_i = 1'b1;
        data_req_i = '0; per_gnt_i = 1'b0; per_r_valid_i = 1'b0;
        per_r_opc_i = 1'b0; per_r_rdata_i = '0;
        data_wen_i = nxt_wen; data_be_i = nxt_be;
        for (int c = 0; c < NB; c++) begin
            data_add_i[c]   = core_addr(c);
            data_wdata_i[c] = core_wdata(c);
        end

        //               req  g rv opc rd      preq sel gnt rv opc
        tbl[0]  = mk(4'hF, 1, 0, 0, 0,      1, 0, 1, 0, 0);
        tbl[1]  = mk(4'hF, 1, 1, 0, 'hD1,   1, 1, 2, 1, 0);
        tbl[2]  = mk(4'hF, 1, 1, 0, 'hD2,   1, 2, 4, 2, 0);
        tbl[3]  = mk(4'hF, 1, 1, 0, 'hD3,   1, 3, 8, 4, 0);
        tbl[4]  = mk(4'hF, 1, 1, 0, 'hD4,   1, 0, 1, 8, 0);
        tbl[5]  = mk(4'hF, 1, 1, 0, 'hD5,   1, 1, 2, 1, 0);
        tbl[6]  = mk(4'hF, 1, 1, 0, 'hD6,   1, 2, 4, 2, 0);
        tbl[7]  = mk(4'h0, 0, 1, 0, 'hD7,   0, 0, 0, 4, 0);
        tbl[8]  = mk(4'h4, 0, 0, 0, 0,      1, 2, 0, 0, 0);
        tbl[9]  = mk(4'h5, 0, 0, 0, 0,      1, 2, 0, 0, 0);
        tbl[10] = mk(4'h5, 0, 0, 0, 0,      1, 2, 0, 0, 0);
        tbl[11] = mk(4'h5, 1, 0, 0, 0,      1, 2, 4, 0, 0);
        tbl[12] = mk(4'h1, 1, 1, 0, 'hDC,   1, 0, 1, 4, 0);
        tbl[13] = mk(4'h2, 1, 0, 0, 0,      1, 1, 2, 0, 0);
        tbl[14] = mk(4'h8, 1, 0, 0, 0,      0, 3, 0, 0, 0);
        tbl[15] = mk(4'h8, 1, 1, 0, 'hDF,   1, 3, 8, 1, 0);
        tbl[16] = mk(4'h0, 0, 1, 1, 'hE0,   0, 0, 0, 2, 1);
        tbl[17] = mk(4'h0, 0, 1, 0, 'hE1,   0, 0, 0, 8, 0);
        tbl[18] = mk(4'h0, 0, 0, 0, 0,      0, 0, 0, 0, 0);

        do_reset();
        chk_out("reset", 4'h0, 4'h0, 1'b0, 32'h0, 1'b0);
        chk("reset_spur", 64'(spurious_rsp_o), 64'd0);

        for (int i = 0; i < 19; i++) begin
            v = tbl[i];
            drive(v.req, v.gnt, v.rv, v.opc, v.rd);
            chk_out($sformatf("vec%0d", i), v.exp_gnt, v.exp_rv, v.exp_opc,
                    (v.exp_rv != 4'h0) ? v.rd : 32'h0, v.exp_preq);
            if (v.exp_preq) begin
                chk($sformatf("vec%0d_add", i), 64'(per_add_o), 64'(core_addr(v.exp_sel)));
                chk($sformatf("vec%0d_wdata", i), 64'(per_wdata_o), 64'(core_wdata(v.exp_sel)));
            end
            $display("vec %0d req=%b gnt=%b rv=%b preq=%b", i, v.req, data_gnt_o, data_r_valid_o, per_req_o);
        end
        chk("table_spur", 64'(spurious_rsp_o), 64'd0);

        // Timeout: one grant to core 1, slave silent; forced error on the 4th waiting cycle.
        drive(4'b0010, 1'b1, 1'b0, 1'b0, 32'h0);
        chk_out("to_grant", 4'b0010, 4'h0, 1'b0, 32'h0, 1'b1);
        for (int w = 1; w <= 4; w++) begin
            drive(4'h0, 1'b0, 1'b0, 1'b0, 32'hBAD0_0000 + 32'(w));
            chk_out($sformatf("to_wait%0d", w), 4'h0, (w == 4) ? 4'b0010 : 4'h0,
                    (w == 4), 32'h0, 1'b0);
        end
        $display("timeout reply: rv=%b opc=%b", data_r_valid_o, data_r_opc_o);
        drive(4'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk_out("to_after", 4'h0, 4'h0, 1'b0, 32'h0, 1'b0);
        drive(4'h0, 1'b0, 1'b1, 1'b0, 32'h1234);
        chk_out("to_late", 4'h0, 4'h0, 1'b0, 32'h0, 1'b0);
        chk("to_spur_pre", 64'(spurious_rsp_o), 64'd0);
        drive(4'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("to_spur", 64'(spurious_rsp_o), 64'd1);

        // Reset with two transactions outstanding (rr pointer is 2 beforehand).
        drive(4'b0011, 1'b1, 1'b0, 1'b0, 32'h0);
        chk_out("rm_g0", 4'b0001, 4'h0, 1'b0, 32'h0, 1'b1);
        drive(4'b0011, 1'b1, 1'b0, 1'b0, 32'h0);
        chk_out("rm_g1", 4'b0010, 4'h0, 1'b0, 32'h0, 1'b1);
        do_reset();
        chk_out("rm_reset", 4'h0, 4'h0, 1'b0, 32'h0, 1'b0);
        chk("rm_spur0", 64'(spurious_rsp_o), 64'd0);
        drive(4'h0, 1'b0, 1'b1, 1'b0, 32'h77);
        chk_out("rm_late", 4'h0, 4'h0, 1'b0, 32'h0, 1'b0);
        drive(4'b1010, 1'b1, 1'b0, 1'b0, 32'h0);
        chk_out("rm_rr0", 4'b0010, 4'h0, 1'b0, 32'h0, 1'b1);
        chk("rm_spur1", 64'(spurious_rsp_o), 64'd1);
        drive(4'b1000, 1'b1, 1'b1, 1'b0, 32'h88);
        chk_out("rm_core3", 4'b1000, 4'b0010, 1'b0, 32'h88, 1'b1);
        drive(4'h0, 1'b0, 1'b1, 1'b0, 32'h99);
        chk_out("rm_drain", 4'h0, 4'b1000, 1'b0, 32'h99, 1'b0);

        // Single requester: core 1 back-to-back for 10 cycles.
        do_reset();
        n_gnt1 = 0; n_rv1 = 0;
        for (int k = 0; k <= 10; k++) begin
            drive((k < 10) ? 4'b0010 : 4'h0, (k < 10), (k > 0), 1'b0, 32'h5000 + 32'(k));
            chk_out($sformatf("single%0d", k), (k < 10) ? 4'b0010 : 4'h0,
                    (k > 0) ? 4'b0010 : 4'h0, 1'b0, (k > 0) ? 32'h5000 + 32'(k) : 32'h0, (k < 10));
            if (data_gnt_o == 4'b0010) n_gnt1++;
            if (data_r_valid_o == 4'b0010) n_rv1++;
        end
        chk("single_ngnt", 64'(n_gnt1), 64'd10);
        chk("single_nrv", 64'(n_rv1), 64'd10);

        // Random traffic with an in-order slave of random latency.
        do_reset();
        model_reset();
        n_hs = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            r_req = 4'($urandom);
            r_g   = ($urandom_range(0, 3) != 0);
            if (pq_t.size() > 0 && pq_t[0] <= cyc && $urandom_range(0, 2) != 0) begin
                r_rv = 1'b1;
                r_rd = pq_d.pop_front();
                void'(pq_t.pop_front());
            end else begin
                r_rv = 1'b0;
                r_rd = $urandom;
            end
            r_opc   = r_rv && ($urandom_range(0, 7) == 0);
            nxt_wen = 4'($urandom);
            nxt_be  = 16'($urandom);
            model_eval(r_req, r_g, r_rv, r_opc, r_rd);
            drive(r_req, r_g, r_rv, r_opc, r_rd);
            chk_out($sformatf("rnd%0d", cyc), e_gnt, e_rv, e_opc, e_rd, e_preq);
            chk($sformatf("rnd%0d_spur", cyc), 64'(spurious_rsp_o), 64'(m_spur));
            if (e_preq) begin
                chk($sformatf("rnd%0d_add", cyc), 64'(per_add_o), 64'(core_addr(e_sel)));
                chk($sformatf("rnd%0d_wen", cyc), 64'(per_wen_o), 64'(nxt_wen[e_sel]));
                chk($sformatf("rnd%0d_be", cyc), 64'(per_be_o), 64'(data_be_i[e_sel]));
            end
            if (per_req_o && per_gnt_i) begin
                pq_d.push_back(per_add_o ^ 32'h5A5A_0000 ^ 32'(cyc));
                pq_t.push_back(cyc + 1);
                n_hs++;
            end
            model_commit(r_g, r_rv);
        end
        $display("random phase: %0d handshakes", n_hs);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
